pipe_stage_reg: RTL

- Parametrised pipeline boundary register; next-generation replacement for the fixed-field stage registers (e.g. MEM/WB).
- Carries LANES independent write channels. Each lane has its own write-enable and a DATA_W payload.
- Adds a valid bit, flush, and a selectable bubble policy. Reads its stall/bubble decision from the shared stall vector at a configurable index.
- Provides saturating bubble/flush event counters for the performance CP0 path.

---
 rtl/pipe_stage_reg.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register.
// LANES independent write channels, each with its own write enable and
// DATA_W payload, plus a stage valid bit, flush, bubble insertion driven
// from a shared stall vector, and saturating bubble/flush event counters.

// One write channel: its enable and payload registers.
module pipe_stage_lane #(
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,   // load the upstream value
    input  logic              kill_i,  // flush or bubble this edge
    input  logic              we_i,    // already masked by in_valid
    input  logic [DATA_W-1:0] data_i,
    output logic              we_o,
    output logic [DATA_W-1:0] data_o
);
    logic              we_q,   we_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next state: kill beats advance; neither means hold.
    always_comb begin
        we_d   = we_q;
        data_d = data_q;
        if (kill_i) begin
            we_d = 1'b0;
            if (CLEAR_DATA) data_d = '0;
        end else if (adv_i) begin
            we_d   = we_i;
            data_d = data_i;
        end
    end

    // Lane state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            data_q <= data_d;
        end
    end

    assign we_o   = we_q;
    assign data_o = data_q;
endmodule

module pipe_stage_reg #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 32,
    parameter int STALL_W    = 6,
    parameter int STAGE_IDX  = 4,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic                    cnt_clr,
    input  logic                    in_valid,
    input  logic [LANES-1:0]        in_we,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    output logic [LANES-1:0]        out_we,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);
    if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_idx
        $error("pipe_stage_reg: STAGE_IDX must lie in 0..STALL_W-2");
    end

    logic s_me, s_nx;
    logic flush_ev, bubble_ev, adv, kill;
    logic stall_unused;

    assign s_me = stall[STAGE_IDX];
    assign s_nx = stall[STAGE_IDX+1];
    // Only two bits of the shared vector belong to this stage.
    assign stall_unused = ^stall;

    // Strict priority: flush, then bubble, then hold, then advance.
    assign flush_ev  = flush;
    assign bubble_ev = !flush && s_me && !s_nx;
    assign adv       = !flush && !s_me;
    assign kill      = flush_ev || bubble_ev;

    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] bub_q,    bub_d;
    logic [CNT_W-1:0] flsh_q,   flsh_d;
    logic [LANES-1:0] lane_we;

    // Valid bit next state: cleared on kill, loaded on advance, else held.
    always_comb begin
        valid_d = valid_q;
        if (kill)     valid_d = 1'b0;
        else if (adv) valid_d = in_valid;
    end

    // Saturating event counters; a clear drops any same-cycle event.
    always_comb begin
        bub_d  = bub_q;
        flsh_d = flsh_q;
        if (cnt_clr) begin
            bub_d  = '0;
            flsh_d = '0;
        end else begin
            if (bubble_ev && bub_q  != '1) bub_d  = bub_q  + 1'b1;
            if (flush_ev  && flsh_q != '1) flsh_d = flsh_q + 1'b1;
        end
    end

    // Stage-level state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            bub_q   <= '0;
            flsh_q  <= '0;
        end else begin
            valid_q <= valid_d;
            bub_q   <= bub_d;
            flsh_q  <= flsh_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pipe_stage_lane #(
            .DATA_W     (DATA_W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .kill_i (kill),
            .we_i   (in_we[k] & in_valid),
            .data_i (in_data[k*DATA_W +: DATA_W]),
            .we_o   (lane_we[k]),
            .data_o (out_data[k*DATA_W +: DATA_W])
        );
    end

    // Enables are gated by valid again so a dead stage can never write.
    assign out_valid  = valid_q;
    assign out_we     = lane_we & {LANES{valid_q}};
    assign bubble_cnt = bub_q;
    assign flush_cnt  = flsh_q;

    a_we_needs_valid: assert property (@(posedge clk) disable iff (rst)
        (|out_we) |-> out_valid);
    // Own-stage running while downstream stalls is a malformed vector.
    a_stall_wellformed: assert property (@(posedge clk) disable iff (rst)
        !(!s_me && s_nx));
endmodule
